seq_playback: RTL and testbench
===============================

// Module: seq_playback
// PURPOSE
//  Transmit side of the (num, pressed) button-event interface. The player path
//  turns buttons into num/pressed; this block drives the same interface from a
//  stored colour sequence, replaying it with fixed on/gap timing.
//  Output feeds the same LED, frequency and speaker consumers as player input.
//  Sequence memory is loaded by the game controller through a write port.
// PARAMETERS
//  MAX_LEN    32  sequence capacity (entries); ADDR_W = clog2(MAX_LEN)
//  ADDR_W     5   write-address / index width
//  ON_TICKS   3   tick pulses each element is held pressed (>=1)
//  GAP_TICKS  1   tick pulses of silence after each element (>=1)
// PORTS
//  clk       in   1       system clock, all logic on rising edge
//  reset     in   1       asynchronous, active-low reset
//  tick      in   1       timing enable, 1-cycle pulse from clock reducer
//  wr_en     in   1       write strobe for sequence memory
//  wr_addr   in   ADDR_W  write index
//  wr_data   in   2       colour to store (0..3)
//  start     in   1       begin playback (level sampled, acts on 1st cycle)
//  length    in   ADDR_W+1 number of elements to play, sampled with start
//  abort     in   1       stop playback immediately, no done
//  num       out  2       current colour; 0 when not busy
//  pressed   out  1       1 while current element is sounding
//  busy      out  1       1 from cycle after start until return to IDLE
//  done      out  1       1-cycle pulse when full sequence has played
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, idx=0, cnt=0; num=0, pressed=0,
//   busy=0, done=0. Sequence memory NOT cleared (contents retained/undefined).
//  All outputs registered. States: IDLE, ON, GAP, FIN.
//  IDLE: wr_en writes mem[wr_addr]<=wr_data; wr_addr>=MAX_LEN ignored.
//   start=1: len<=min(length,MAX_LEN); idx<=0; cnt<=0.
//    len==0 -> FIN (no press). else -> ON; next cycle pressed=1,
//    num=mem[0], busy=1.
//  ON: cnt increments on tick; on tick with cnt==ON_TICKS-1: cnt<=0,
//   ->GAP, pressed<=0 (num holds).
//  GAP: on tick with cnt==GAP_TICKS-1: cnt<=0; if idx==len-1 -> FIN,
//   else idx<=idx+1, ->ON, num<=mem[idx+1], pressed<=1.
//  FIN: one cycle; done=1, busy=0, num=0, pressed=0; ->IDLE.
//  Cycles without tick never advance cnt or state (except IDLE/FIN).
//  start while not IDLE: ignored. wr_en while not IDLE: ignored (memory
//   stable during playback).
//  abort (any non-IDLE state, priority over tick): ->IDLE next cycle,
//   pressed=0, num=0, busy=0, done stays 0. abort with start in IDLE:
//   abort wins, stays IDLE.
//  tick coincident with start: not counted (counting begins in ON).
//  Every element is pressed exactly ON_TICKS ticks, silent exactly GAP_TICKS
//   ticks; last gap precedes done.
//  length>MAX_LEN clamps to MAX_LEN; index never wraps.
//  Reset asserted mid-playback: outputs 0 immediately; after release, IDLE.
// TESTING
//  1 load mem[0..3]=2,0,3,1; start len=4, tick every 4 clk -> num 2,0,3,1,
//    each pressed 3 ticks, 1-tick gap, done 1 pulse after 16 ticks.
//  2 start len=0 -> done=1 cycle after start, pressed never 1, busy never 1.
//  3 abort during 3rd element -> pressed=0,busy=0 next cycle, done never 1;
//    new start len=2 replays mem[0],mem[1].
//  4 wr_en mem[0]=3 during playback of len=1 (mem[0]=1) -> plays 1; after
//    done, mem[0] still 1.
//  5 length=40, MAX_LEN=32 -> exactly 32 presses, then done.
//  6 reset low mid-ON -> num=0,pressed=0 without clk edge; release -> IDLE.

Source files
------------

// File: rtl/seq_playback.sv
// Replays a stored colour sequence onto the (num, pressed) button-event bus.
// Each element sounds for ON_TICKS ticks followed by GAP_TICKS ticks of silence.
module seq_playback #(
  parameter int MAX_LEN   = 32,
  parameter int ADDR_W    = $clog2(MAX_LEN),
  parameter int ON_TICKS  = 3,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic [1:0]        num,
  output logic              pressed,
  output logic              busy,
  output logic              done
);

  localparam int MAXT  = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int CNT_W = (MAXT > 1) ? $clog2(MAXT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP,
    FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        mem [MAX_LEN];

  logic [ADDR_W:0] len_clamp;
  logic            wr_ok;
  logic            last;

  assign len_clamp = (int'(length) > MAX_LEN) ?
                     (ADDR_W+1)'(MAX_LEN) : length;
  assign wr_ok     = wr_en && (state == IDLE) &&
                     (int'(wr_addr) < MAX_LEN);
  assign last      = ({1'b0, idx} == len - (ADDR_W+1)'(1));

  // Memory is deliberately not reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      len     <= '0;
      cnt     <= '0;
      num     <= '0;
      pressed <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state   <= IDLE;
        cnt     <= '0;
        num     <= '0;
        pressed <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              len <= len_clamp;
              idx <= '0;
              cnt <= '0;
              if (len_clamp == '0) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                state   <= ON;
                num     <= mem[0];
                pressed <= 1'b1;
                busy    <= 1'b1;
              end
            end
          end
          ON: begin
            if (tick) begin
              if (cnt == CNT_W'(ON_TICKS - 1)) begin
                cnt     <= '0;
                state   <= GAP;
                pressed <= 1'b0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          GAP: begin
            if (tick) begin
              if (cnt == CNT_W'(GAP_TICKS - 1)) begin
                cnt <= '0;
                if (last) begin
                  state <= FIN;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  num   <= '0;
                end else begin
                  idx     <= idx + ADDR_W'(1);
                  num     <= mem[idx + ADDR_W'(1)];
                  pressed <= 1'b1;
                  state   <= ON;
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          FIN: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_playback.sv
// Bench for seq_playback: tick-count model of the replay plus directed
// scenarios with literal expectations.
module tb_seq_playback;

  localparam int ML  = 32;
  localparam int ONT = 3;
  localparam int GPT = 1;
  localparam int P   = ONT + GPT;

  logic       clk = 0;
  logic       reset = 0;
  logic       tick = 0;
  logic       wr_en = 0;
  logic [4:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic       start = 0;
  logic [5:0] length = '0;
  logic       abort = 0;
  logic [1:0] num;
  logic       pressed, busy, done;

  seq_playback #(
    .MAX_LEN(ML), .ADDR_W(5), .ON_TICKS(ONT), .GAP_TICKS(GPT)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .length(length), .abort(abort), .num(num), .pressed(pressed),
    .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int tick_per = 0;
  initial begin
    int tc = 0;
    forever begin
      @(negedge clk);
      if (tick_per > 0) begin
        tc++;
        if (tc >= tick_per) begin
          tick = 1;
          tc = 0;
        end else tick = 0;
      end else begin
        tick = 0;
        tc = 0;
      end
    end
  end

  // Model: playback is a count t of ticks since start; element t/P,
  // sounding while t%P < ON_TICKS, finished when t reaches len*P.
  logic [1:0] mmem [ML];
  bit m_act = 0, m_fin = 0;
  int m_t = 0, m_len = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act = 0;
      m_fin = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_act) begin
      if (abort) m_act = 0;
      else if (tick) begin
        m_t++;
        if (m_t == m_len * P) begin
          m_act = 0;
          m_fin = 1;
        end
      end
    end else begin
      if (wr_en && int'(wr_addr) < ML) mmem[wr_addr] = wr_data;
      if (start && !abort) begin
        m_len = (int'(length) > ML) ? ML : int'(length);
        m_t = 0;
        if (m_len == 0) m_fin = 1;
        else m_act = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("num", num, m_act ? mmem[m_t / P] : 2'd0);
    check("pressed", pressed, m_act && (m_t % P) < ONT);
    check("busy", busy, m_act);
    check("done", done, m_fin);
  end

  int presses = 0, busy_cyc = 0, dones = 0, nticks = 0;
  logic [1:0] seen[$];
  logic prev_p = 0;
  always @(negedge clk) begin
    if (pressed && !prev_p) begin
      presses++;
      seen.push_back(num);
    end
    prev_p = pressed;
    if (busy) busy_cyc++;
    if (done) dones++;
  end
  always @(posedge clk) if (tick) nticks++;

  task automatic write(input int a, input int d);
    @(negedge clk);
    wr_en = 1;
    wr_addr = 5'(a);
    wr_data = 2'(d);
    @(negedge clk);
    wr_en = 0;
  endtask

  int n0;
  task automatic do_start(input int len);
    @(negedge clk);
    start = 1;
    length = 6'(len);
    @(posedge clk);
    #1 n0 = nticks;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(nm, done, 1);
  endtask

  task automatic wait_presses(input int target, input string nm);
    int k = 0;
    while (presses < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(nm, presses >= target, 1);
  endtask

  int pb, qb, bb, db;
  initial begin
    repeat (2) @(negedge clk);
    check("rst_num", num, 0);
    check("rst_pressed", pressed, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1;
    @(negedge clk);

    // 1: basic replay
    write(0, 2); write(1, 0); write(2, 3); write(3, 1);
    tick_per = 4;
    pb = presses; qb = seen.size();
    do_start(4);
    wait_done(400, "t1_done");
    check("t1_ticks", nticks - n0, 16);
    check("t1_presses", presses - pb, 4);
    check("t1_n0", seen[qb], 2);
    check("t1_n1", seen[qb+1], 0);
    check("t1_n2", seen[qb+2], 3);
    check("t1_n3", seen[qb+3], 1);

    // 2: zero length
    pb = presses; bb = busy_cyc;
    do_start(0);
    check("t2_done", done, 1);
    repeat (3) @(negedge clk);
    check("t2_presses", presses - pb, 0);
    check("t2_busy", busy_cyc - bb, 0);

    // 3: abort in third element, then replay two
    tick_per = 2;
    pb = presses; db = dones;
    do_start(4);
    wait_presses(pb + 3, "t3_reach");
    check("t3_num", num, 3);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("t3_pressed", pressed, 0);
    check("t3_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("t3_nodone", dones - db, 0);
    @(negedge clk);
    start = 1; abort = 1; length = 6'd2;
    @(negedge clk);
    start = 0; abort = 0;
    check("t3_abwins", busy, 0);
    pb = presses; qb = seen.size();
    do_start(2);
    wait_done(300, "t3_done");
    check("t3_presses", presses - pb, 2);
    check("t3_n0", seen[qb], 2);
    check("t3_n1", seen[qb+1], 0);

    // 4: write during playback is ignored
    write(0, 1);
    qb = seen.size();
    do_start(1);
    write(0, 3);
    wait_done(300, "t4_done");
    do_start(1);
    wait_done(300, "t4_done2");
    check("t4_n0", seen[qb], 1);
    check("t4_n1", seen[qb+1], 1);

    // 5: length clamps to capacity
    for (int i = 0; i < ML; i++) write(i, (i * 3) % 4);
    tick_per = 1;
    pb = presses;
    do_start(40);
    wait_done(800, "t5_done");
    check("t5_presses", presses - pb, 32);
    check("t5_ticks", nticks - n0, 32 * P);

    // 6: async reset mid-ON
    tick_per = 3;
    pb = presses;
    do_start(4);
    wait_presses(pb + 1, "t6_reach");
    #2 reset = 0;
    #1;
    check("t6_num", num, 0);
    check("t6_pressed", pressed, 0);
    check("t6_busy", busy, 0);
    @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    check("t6_idle", busy, 0);
    pb = presses;
    do_start(2);
    wait_done(300, "t6_done");
    check("t6_presses", presses - pb, 2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
